// File: rtl/mux153_rr_sched_if.sv
// Bus between the requesters and the round-robin scheduler of a shared 153-style 4:1 mux.
// The master side drives requests; the slave side (the scheduler) drives grant and mux controls.
interface mux153_rr_sched_if;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       S1;
  logic       S0;
  logic       E;
  logic       BUSY;

  modport master (output REQ, input GNT, S1, S0, E, BUSY);
  modport slave  (input REQ, output GNT, S1, S0, E, BUSY);
endinterface

// File: rtl/mux153_rr_sched.sv
// Round-robin scheduler for one shared 153-style 4:1 mux: bounded bursts, registered S1/S0/E.
// Optional feature: define MUX153_GUARD_EN to insert a 1-cycle E=1 guard gap after every release.
module mux153_rr_sched #(
  parameter int BURST = 4,
  parameter int CNT_W = 3
) (
  input  logic               CLK,
  input  logic               RST,
  mux153_rr_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef MUX153_GUARD_EN
    ST_GUARD = 2'd2,
`endif
    ST_GRANT = 2'd1
  } state_t;

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Winner search from last+1 round to last; returns {found, index}.
  function automatic logic [2:0] pick_winner(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + k[1:0];
      if (req[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;

  logic [2:0]       win_idle;
  logic             release_now;
`ifndef MUX153_GUARD_EN
  logic [2:0]       win_rel;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    e_d         = e_q;
    busy_d      = busy_q;
    win_idle    = pick_winner(bus.REQ, last_q);
    // During a grant sel_q is the owner, so the post-release search starts after it.
    release_now = (bus.REQ[sel_q] == 1'b0) || (cnt_q == BURST_C);
`ifndef MUX153_GUARD_EN
    win_rel     = pick_winner(bus.REQ, sel_q);
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_idle[2]) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << win_idle[1:0];
          sel_d   = win_idle[1:0];
          e_d     = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          e_d     = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      ST_GRANT: begin
        if (release_now) begin
          last_d = sel_q;
`ifdef MUX153_GUARD_EN
          state_d = ST_GUARD;
          gnt_d   = 4'b0000;
          e_d     = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
`else
          if (win_rel[2]) begin
            state_d = ST_GRANT;
            gnt_d   = 4'b0001 << win_rel[1:0];
            sel_d   = win_rel[1:0];
            e_d     = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            e_d     = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

`ifdef MUX153_GUARD_EN
      // Guard arbitrates exactly like idle; last_q was already updated on release.
      ST_GUARD: begin
        if (win_idle[2]) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << win_idle[1:0];
          sel_d   = win_idle[1:0];
          e_d     = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          e_d     = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        e_d     = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; synchronous reset returns everything to idle with last=3.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      e_q     <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.GNT  = gnt_q;
  assign bus.S1   = sel_q[1];
  assign bus.S0   = sel_q[0];
  assign bus.E    = e_q;
  assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_mux153_rr_sched.sv
// Bench for mux153_rr_sched: BURST=4 and BURST=1 instances against a per-cycle behavioural model,
// plus directed literal expectations; honours MUX153_GUARD_EN when defined.
module tb_mux153_rr_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   done = 1'b0;
  bit   model_ok = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux153_rr_sched_if if0 ();
  mux153_rr_sched_if if1 ();

  mux153_rr_sched #(.BURST(4), .CNT_W(3)) dut0 (.CLK(clk), .RST(rst), .bus(if0));
  mux153_rr_sched #(.BURST(1), .CNT_W(2)) dut1 (.CLK(clk), .RST(rst), .bus(if1));

  // Model: owner index (-1 when no grant), cycles used by the current grant, last owner, select.
  int m_owner [2];
  int m_used  [2];
  int m_last  [2];
  int m_sel   [2];
  int burst_of [2] = '{4, 1};

  function automatic int search(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input int k, input logic [3:0] req, input logic r);
    int w;
    if (r) begin
      m_owner[k] = -1; m_used[k] = 0; m_last[k] = 3; m_sel[k] = 0;
      return;
    end
    if (m_owner[k] >= 0) begin
      if (req[m_owner[k]] && m_used[k] < burst_of[k]) begin
        m_used[k]++;
        return;
      end
      m_last[k]  = m_owner[k];
      m_owner[k] = -1;
`ifdef MUX153_GUARD_EN
      return;
`endif
    end
    w = search(req, m_last[k]);
    if (w >= 0) begin
      m_owner[k] = w; m_used[k] = 1; m_sel[k] = w;
    end
  endtask

  function automatic logic [3:0] m_gnt(input int k);
    return (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    model_step(0, if0.REQ, rst);
    model_step(1, if1.REQ, rst);
    if (rst) model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok && !done) begin
      chk("d0_gnt",  if0.GNT, m_gnt(0));
      chk("d0_sel",  {2'b00, if0.S1, if0.S0}, 4'(m_sel[0]));
      chk("d0_e",    {3'b000, if0.E}, {3'b000, (m_owner[0] < 0)});
      chk("d0_busy", {3'b000, if0.BUSY}, {3'b000, (m_owner[0] >= 0)});
      chk("d1_gnt",  if1.GNT, m_gnt(1));
      chk("d1_sel",  {2'b00, if1.S1, if1.S0}, 4'(m_sel[1]));
      chk("d1_e",    {3'b000, if1.E}, {3'b000, (m_owner[1] < 0)});
      chk("d1_busy", {3'b000, if1.BUSY}, {3'b000, (m_owner[1] >= 0)});
    end
  end

  task automatic cyc(input logic [3:0] r0, input logic [3:0] r1, input logic r);
    if0.REQ = r0;
    if1.REQ = r1;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pin0(input string name, input logic [3:0] g, input logic [1:0] s, input logic e, input logic b);
    chk({name, "_gnt"}, if0.GNT, g);
    chk({name, "_sel"}, {2'b00, if0.S1, if0.S0}, {2'b00, s});
    chk({name, "_e"}, {3'b000, if0.E}, {3'b000, e});
    chk({name, "_busy"}, {3'b000, if0.BUSY}, {3'b000, b});
  endtask

  initial begin
    logic [3:0] r0, r1, exp_g;
    logic       rr;

    // Reset held with all requests active.
    cyc(4'b1111, 4'b1111, 1'b1);
    pin0("rst_a", 4'b0000, 2'b00, 1'b1, 1'b0);
    cyc(4'b1111, 4'b1111, 1'b1);
    pin0("rst_b", 4'b0000, 2'b00, 1'b1, 1'b0);

    // Single requester 2: four cycles, then regrant (or a guard gap first).
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0100, 4'b0000, 1'b0);
      pin0("single2", 4'b0100, 2'b10, 1'b0, 1'b1);
    end
    cyc(4'b0100, 4'b0000, 1'b0);
`ifdef MUX153_GUARD_EN
    pin0("single2_gap", 4'b0000, 2'b10, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0000, 1'b0);
`endif
    pin0("single2_re", 4'b0100, 2'b10, 1'b0, 1'b1);

    // All requesting: 0,1,2,3,0 each for four cycles.
    cyc(4'b1111, 4'b0000, 1'b1);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        cyc(4'b1111, 4'b0000, 1'b0);
        exp_g = 4'(1 << (g % 4));
        pin0("rr_all", exp_g, 2'(g % 4), 1'b0, 1'b1);
      end
`ifdef MUX153_GUARD_EN
      if (g < 4) begin
        cyc(4'b1111, 4'b0000, 1'b0);
        chk("rr_all_gap", if0.GNT, 4'b0000);
      end
`endif
    end

    // Owner 0 drops after two cycles; requester 1 takes over.
    cyc(4'b0011, 4'b0000, 1'b1);
    cyc(4'b0011, 4'b0000, 1'b0);
    pin0("drop_a", 4'b0001, 2'b00, 1'b0, 1'b1);
    cyc(4'b0011, 4'b0000, 1'b0);
    cyc(4'b0010, 4'b0000, 1'b0);
`ifdef MUX153_GUARD_EN
    pin0("drop_gap", 4'b0000, 2'b00, 1'b1, 1'b0);
    cyc(4'b0010, 4'b0000, 1'b0);
`endif
    pin0("drop_b", 4'b0010, 2'b01, 1'b0, 1'b1);

    // Reset in the third cycle of a grant to 2; next grant goes to 0.
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b0);
    pin0("midrst_pre", 4'b0100, 2'b10, 1'b0, 1'b1);
    cyc(4'b1111, 4'b0000, 1'b1);
    pin0("midrst", 4'b0000, 2'b00, 1'b1, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b0);
    pin0("midrst_post", 4'b0001, 2'b00, 1'b0, 1'b1);

    // BURST=1 instance with requesters 1 and 3.
    cyc(4'b0000, 4'b1010, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(4'b0000, 4'b1010, 1'b0);
`ifdef MUX153_GUARD_EN
      exp_g = (i % 4 == 0) ? 4'b0010 : ((i % 4 == 2) ? 4'b1000 : 4'b0000);
`else
      exp_g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
      chk("burst1_gnt", if1.GNT, exp_g);
    end

    // Randomized traffic with sticky requests and occasional resets.
    r0 = 4'b0000;
    r1 = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r0[b] = ~r0[b];
        if ($urandom_range(0, 3) == 0) r1[b] = ~r1[b];
      end
      rr = ($urandom_range(0, 99) == 0);
      cyc(r0, r1, rr);
    end

    @(negedge clk);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
